// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Purpose  : Sequential shift-and-add multiplier. Operands are sampled on an
//            accepted start, one multiplier bit is processed per cycle for
//            WIDTH cycles, and the 2*WIDTH-bit product is published when the
//            DONE state is entered. Signed mode multiplies magnitudes and
//            negates the result when the operand signs differ.
// Ports    : clk         - clock, rising edge
//            rst         - synchronous active-high reset
//            start       - begin a multiply (accepted in IDLE or DONE)
//            signed_mode - 1 = two's-complement operands, 0 = unsigned
//            a, b        - multiplicand / multiplier (WIDTH bits)
//            busy        - high while the multiply is running
//            done        - one-cycle pulse, product valid
//            product     - result of the last completed multiply
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int              c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;

    logic [2*WIDTH-1:0]   r_mcand;     // shifted multiplicand magnitude
    logic [WIDTH-1:0]     r_mplier;    // shifted multiplier magnitude
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_neg;       // result sign, from latched mode + operand signs
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;

    // Magnitudes are taken as unsigned WIDTH-bit values, so the most negative
    // operand maps to 2**(WIDTH-1) without overflow.
    assign w_a_neg = signed_mode & a[WIDTH-1];
    assign w_b_neg = signed_mode & b[WIDTH-1];
    assign w_mag_a = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_mag_b = w_b_neg ? (~b + WIDTH'(1)) : b;

    assign w_accept   = start && ((r_state == c_idle) || (r_state == c_done));
    assign w_last     = (r_cnt == c_last);
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (start) w_next_state = c_run;
            c_run:   if (w_last) w_next_state = c_done;
            c_done:  w_next_state = start ? c_run : c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Datapath: operand capture, shift-add iteration, result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= w_a_neg ^ w_b_neg;
        end else if (r_state == c_run) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cnt_one;
            // The final add lands in the same edge that enters DONE, so the
            // product is formed from the combinational next accumulator.
            if (w_last) begin
                r_product <= r_neg ? -w_acc_next : w_acc_next;
            end
        end
    end

    assign busy    = (r_state == c_run);
    assign done    = (r_state == c_done);
    assign product = r_product;

endmodule
`default_nettype wire

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port: start  input  1  request to begin a multiply; sampled on the rising edge.
REQ-005 SHALL provide port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL provide port: a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL provide port: b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL provide port: busy  output  1  high while a multiply is in progress.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse marking product valid.
REQ-010 SHALL provide port: product  output  2*WIDTH  result of the last completed multiply.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 SHALL accept start only in IDLE or DONE; on acceptance, SHALL latch a, b and signed_mode, clear the internal accumulator and bit counter, and enter RUN.
REQ-013 SHALL ignore start while in RUN; latched operands and progress are unaffected.
REQ-014 SHALL, in RUN, process one multiplier bit per cycle: if the current LSB of the shifted multiplier is 1, add the shifted multiplicand magnitude to the 2*WIDTH-bit accumulator; shift the multiplicand left and the multiplier right by one.
REQ-015 SHALL leave RUN for DONE after exactly WIDTH RUN cycles; the bit counter wraps nowhere else and SHALL NOT terminate early on zero operands.
REQ-016 SHALL, in unsigned mode, produce product = a * b, exact, in 2*WIDTH bits.
REQ-017 SHALL, in signed mode, multiply operand magnitudes and negate the result when the operand signs differ, giving the exact two's-complement product in 2*WIDTH bits, including most-negative * most-negative.
REQ-018 SHALL assert busy exactly in RUN, i.e. for WIDTH cycles starting the cycle after start is accepted.
REQ-019 SHALL assert done exactly in the DONE state, for one cycle, WIDTH+1 cycles after the accepting edge.
REQ-020 SHALL update product only on entry to DONE; product SHALL hold its value until the next DONE entry, including across later accepted starts.
REQ-021 SHALL return from DONE to IDLE after one cycle when start is low, or go directly to RUN when start is high (back-to-back operation, no idle gap).
REQ-022 SHALL ignore changes on a, b and signed_mode outside the accepting edge.

Reset
REQ-023 SHALL, on rst high at a rising edge, enter IDLE and drive busy=0, done=0, product=0, and clear the accumulator, counter and latched operands.
REQ-024 SHALL give rst priority over start; a reset mid-RUN aborts the operation with no done pulse and product=0.
REQ-025 SHALL accept a start on the first edge after rst deasserts.

Verification (WIDTH=8)
REQ-026 SHALL verify unsigned: start with a=8'hFF, b=8'hFF, signed_mode=0 -> busy high 8 cycles, done pulse at cycle 9, product=16'hFE01.
REQ-027 SHALL verify signed: a=8'h80, b=8'h80, signed_mode=1 -> product=16'h4000; a=8'hFD (-3), b=8'h05 -> product=16'hFFF1 (-15).
REQ-028 SHALL verify zero/identity: a=8'h00, b=8'hA5 -> product=16'h0000 after the full 9-cycle latency; a=8'h01, b=8'hA5 unsigned -> 16'h00A5.
REQ-029 SHALL verify handshake: start pulsed again mid-RUN with different operands -> ignored, first result delivered; start held high during the DONE cycle -> second operation begins with no IDLE cycle and product holds the first result until the second done.
REQ-030 SHALL verify reset: rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, product=0, no done pulse follows; new start after rst release completes normally.
REQ-031 SHALL verify randomized operands in both modes against a reference model, checking the product at every done pulse and that done never coincides with busy.
